// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: sequences single-access enable pulses to the
// byte-addressed data memory, checks alignment/range, and extends load data.
module lsu_mem_initiator #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned XLEN      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data_input,
    output logic            mem_write_en,
    output logic            mem_read_en,
    output logic [2:0]      load_format,
    output logic [1:0]      store_format,
    input  logic [XLEN-1:0] mem_data_output
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state;
    logic        r_is_store;
    logic [2:0]  r_funct3;

    logic [3:0]  size_bytes;
    logic [2:0]  align_mask;
    logic [XLEN:0] end_addr;
    logic        chk_illegal;
    logic        chk_misaligned;
    logic        chk_range;

    // mem_addr doubles as the registered request address.
    always_comb begin
        size_bytes = 4'd1;
        align_mask = 3'b000;
        case (r_funct3[1:0])
            2'b00: begin size_bytes = 4'd1; align_mask = 3'b000; end
            2'b01: begin size_bytes = 4'd2; align_mask = 3'b001; end
            2'b10: begin size_bytes = 4'd4; align_mask = 3'b011; end
            default: begin size_bytes = 4'd8; align_mask = 3'b111; end
        endcase
        end_addr       = {1'b0, mem_addr} + (XLEN+1)'(size_bytes);
        chk_illegal    = r_is_store ? r_funct3[2] : (r_funct3 == 3'b111);
        chk_misaligned = (mem_addr[2:0] & align_mask) != 3'b000;
        chk_range      = end_addr > (XLEN+1)'(MEM_BYTES);
    end

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  extend = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b010:  extend = {{(XLEN-32){d[31]}}, d[31:0]};
            3'b100:  extend = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(XLEN-16){1'b0}}, d[15:0]};
            3'b110:  extend = {{(XLEN-32){1'b0}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic [2:0] load_fmt(input logic [1:0] sz);
        case (sz)
            2'b00:   load_fmt = 3'b000;
            2'b01:   load_fmt = 3'b001;
            2'b10:   load_fmt = 3'b010;
            default: load_fmt = 3'b101;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            r_is_store      <= 1'b0;
            r_funct3        <= '0;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_fault      <= 1'b0;
            mem_addr        <= '0;
            mem_data_input  <= '0;
            mem_write_en    <= 1'b0;
            mem_read_en     <= 1'b0;
            load_format     <= '0;
            store_format    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_is_store     <= req_is_store;
                        r_funct3       <= req_funct3;
                        mem_addr       <= req_addr;
                        mem_data_input <= req_wdata;
                        load_format    <= load_fmt(req_funct3[1:0]);
                        store_format   <= req_funct3[1:0];
                        req_ready      <= 1'b0;
                        state          <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (chk_illegal || chk_misaligned || chk_range) begin
                        resp_valid      <= 1'b1;
                        resp_rdata      <= '0;
                        resp_fault      <= chk_illegal || (!chk_misaligned && chk_range);
                        resp_misaligned <= !chk_illegal && chk_misaligned;
                        state           <= DONE;
                    end else begin
                        mem_write_en <= r_is_store;
                        mem_read_en  <= !r_is_store;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write_en    <= 1'b0;
                    mem_read_en     <= 1'b0;
                    resp_rdata      <= r_is_store ? '0 : extend(r_funct3, mem_data_output);
                    resp_misaligned <= 1'b0;
                    resp_fault      <= 1'b0;
                    resp_valid      <= 1'b1;
                    state           <= DONE;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
